gpio_stim_seq: RTL and testbench
================================

GPIO_STIM_SEQ -- requirements
Module: gpio_stim_seq

Interface
REQ-001 The block SHALL have parameter NUM_GPIO, default 32: width of the DUT GPIO buses.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of script entries.
REQ-003 The block SHALL have parameter ARG_W, default 24: width of the per-entry delay/timeout argument.
REQ-004 The block SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 The block SHALL have port start_i, input, 1: one-cycle pulse that runs the script from entry 0.
REQ-007 The block SHALL have port gpio_out_i, input, NUM_GPIO: DUT gpio_out, observed by WAIT entries.
REQ-008 The block SHALL have port gpio_in_o, output, NUM_GPIO: stimulus to DUT gpio_in.
REQ-009 The block SHALL have port prog_we_i, input, 1: script entry write strobe.
REQ-010 The block SHALL have port prog_addr_i, input, $clog2(DEPTH): entry index to write.
REQ-011 The block SHALL have port prog_data_i, input, ENTRY_W: entry {op[2:0], idx[$clog2(NUM_GPIO)-1:0], val, arg[ARG_W-1:0]}.
REQ-012 The block SHALL have ports busy_o, done_o and error_o, output, 1 each: run status.
REQ-013 The block SHALL have port err_code_o, output, 2: error cause, 01 = timeout, 10 = illegal opcode.
REQ-014 The block SHALL have port fail_pc_o, output, $clog2(DEPTH): index of the entry that caused the error.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE and ERR; start_i SHALL be accepted in IDLE, DONE and ERR, clear done_o/error_o/err_code_o, set pc=0 and enter RUN the next cycle.
REQ-016 start_i in RUN SHALL be ignored; prog_we_i in RUN SHALL be ignored; in any other state prog_we_i SHALL write the entry in one cycle.
REQ-017 In RUN, the entry at pc SHALL be decoded combinationally from the script array: no fetch cycle.
REQ-018 NOP (0) SHALL take 1 cycle.
REQ-019 DRIVE (1) SHALL set gpio_in_o[idx]=val at the edge ending its single cycle.
REQ-020 WAIT_HIGH (2) / WAIT_LOW (3) SHALL advance in the first cycle where gpio_out_i[idx] is 1 / 0 (minimum 1 cycle).
REQ-021 For WAIT_HIGH and WAIT_LOW, arg=0 SHALL mean wait forever; otherwise, if the condition is still false after arg cycles, the block SHALL enter ERR with err_code=01.
REQ-022 DELAY (4) SHALL hold for max(arg,1) cycles.
REQ-023 END (5) SHALL enter DONE in 1 cycle; opcodes 6/7 SHALL enter ERR with err_code=10.
REQ-024 A single ARG_W cycle counter SHALL be cleared on every pc advance and SHALL saturate rather than wrap.
REQ-025 Completing entry DEPTH-1 without END SHALL enter DONE; pc SHALL NOT wrap.
REQ-026 busy_o SHALL be 1 exactly in RUN; done_o SHALL be 1 in DONE; error_o SHALL be 1 in ERR; in ERR, fail_pc_o SHALL hold the pc of the entry that caused the error.
REQ-027 gpio_in_o SHALL retain its value across runs, DONE and ERR; it SHALL change only through DRIVE or reset.
REQ-028 idx >= NUM_GPIO SHALL be treated as an illegal opcode (err_code=10).

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, pc=0, counter=0, gpio_in_o=0, busy/done/error=0, err_code_o=0 and fail_pc_o=0, including mid-run.
REQ-030 Reset SHALL NOT clear the script array; its contents SHALL be undefined until written.

Configuration
REQ-031 With GPIO_STIM_SYNC_EN defined, gpio_out_i SHALL pass through a 2-flop synchronizer before WAIT evaluation, adding exactly 2 cycles of observation latency.
REQ-032 Without GPIO_STIM_SYNC_EN, gpio_out_i SHALL be used directly, with zero added latency.

Structure
REQ-033 Package gpio_stim_pkg SHALL hold the opcode enum, the entry struct and the err_code constants.
REQ-034 The optional synchronizer SHALL be a sub-module named gpio_stim_sync, parameterised by width.
REQ-035 The script store SHALL be a flop array; no memory macro SHALL be used.

Verification
REQ-036 Script {DRIVE 4=1, END}, start -> gpio_in_o[4]=1 one cycle after entering RUN; done_o=1 on the next cycle; busy_o high for exactly 2 cycles.
REQ-037 Script {WAIT_HIGH 0 arg=0, DRIVE 7=1, END}, with gpio_out_i[0] raised 50 cycles after start -> gpio_in_o[7]=1 one cycle after the rise (three cycles after the rise with GPIO_STIM_SYNC_EN).
REQ-038 Script {WAIT_LOW 3 arg=10, END}, with gpio_out_i[3] held high -> error_o=1, err_code_o=01 and fail_pc_o=0 after 10 cycles of waiting.
REQ-039 Script {DELAY 100, opcode 7} -> ERR with err_code_o=10 and fail_pc_o=1, reached 101 cycles after entering RUN.
REQ-040 All 16 entries programmed as DRIVE with no END -> DONE after 16 cycles; a second start_i reruns the script; a start_i pulse mid-run is ignored.
REQ-041 rst_n asserted during a DELAY 1000 entry -> IDLE and gpio_in_o=0 on the next edge; the script array is intact, and a start_i after reset reruns the same script.

Source files
------------

// File: rtl/gpio_stim_pkg.sv
// Shared types for the GPIO stimulus sequencer: opcodes, script entry layout
// for the default geometry (32 GPIOs, 24-bit argument) and error codes.
package gpio_stim_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_DRIVE     = 3'd1,
    OP_WAIT_HIGH = 3'd2,
    OP_WAIT_LOW  = 3'd3,
    OP_DELAY     = 3'd4,
    OP_END       = 3'd5,
    OP_ILL6      = 3'd6,
    OP_ILL7      = 3'd7
  } op_e;

  localparam int DEF_NUM_GPIO = 32;
  localparam int DEF_ARG_W    = 24;
  localparam int DEF_IDX_W    = $clog2(DEF_NUM_GPIO);

  typedef struct packed {
    op_e                  op;
    logic [DEF_IDX_W-1:0] idx;
    logic                 val;
    logic [DEF_ARG_W-1:0] arg;
  } entry_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

endpackage

// File: rtl/gpio_stim_sync.sv
// Two-flop synchronizer for the observed DUT gpio_out bus (used only when
// GPIO_STIM_SYNC_EN is defined in the top).
module gpio_stim_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_stim_seq.sv
// Script-driven GPIO stimulus sequencer. Define GPIO_STIM_SYNC_EN to pass
// gpio_out_i through a 2-flop synchronizer before WAIT evaluation.
//
// state | meaning
// IDLE  | after reset, script may be programmed, waits for start_i
// RUN   | executing entry at pc, one decode per cycle, no fetch cycle
// DONE  | END reached or last entry completed; start_i reruns
// ERR   | timeout or illegal entry; err_code_o/fail_pc_o hold the cause
module gpio_stim_seq
  import gpio_stim_pkg::*;
#(
  parameter int NUM_GPIO = 32,
  parameter int DEPTH    = 16,
  parameter int ARG_W    = 24,
  localparam int IDX_W   = $clog2(NUM_GPIO),
  localparam int PC_W    = $clog2(DEPTH),
  localparam int ENTRY_W = 3 + IDX_W + 1 + ARG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [NUM_GPIO-1:0] gpio_out_i,
  output logic [NUM_GPIO-1:0] gpio_in_o,
  input  logic                prog_we_i,
  input  logic [PC_W-1:0]     prog_addr_i,
  input  logic [ENTRY_W-1:0]  prog_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [1:0]          err_code_o,
  output logic [PC_W-1:0]     fail_pc_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_e;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DEPTH - 1);
  localparam logic [ARG_W-1:0] CNT_MAX  = '1;
  localparam int               IDX_SPAN = 1 << IDX_W;

  state_e              state;
  logic [PC_W-1:0]     pc;
  logic [ARG_W-1:0]    cnt;
  logic [ENTRY_W-1:0]  script [DEPTH];
  logic [NUM_GPIO-1:0] gpio_obs;

`ifdef GPIO_STIM_SYNC_EN
  gpio_stim_sync #(.WIDTH(NUM_GPIO)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_out_i),
    .q     (gpio_obs)
  );
`else
  assign gpio_obs = gpio_out_i;
`endif

  always_ff @(posedge clk) begin
    if (prog_we_i && (state != ST_RUN)) begin
      script[prog_addr_i] <= prog_data_i;
    end
  end

  logic [ENTRY_W-1:0] cur;
  op_e                cur_op;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_val;
  logic [ARG_W-1:0]   cur_arg;
  logic [ARG_W-1:0]   arg_m1;
  logic               idx_bad;

  assign cur     = script[pc];
  assign cur_op  = op_e'(cur[ENTRY_W-1 -: 3]);
  assign cur_idx = cur[ARG_W+1 +: IDX_W];
  assign cur_val = cur[ARG_W];
  assign cur_arg = cur[ARG_W-1:0];
  assign arg_m1  = cur_arg - ARG_W'(1);

  // Index range only matters when NUM_GPIO is not a power of two.
  if (NUM_GPIO < IDX_SPAN) begin : g_idx_chk
    assign idx_bad = (int'(cur_idx) >= NUM_GPIO);
  end else begin : g_idx_full
    assign idx_bad = 1'b0;
  end

  logic       advance;
  logic       do_err;
  logic [1:0] err_sel;
  logic       wait_hit;

  always_comb begin
    advance  = 1'b0;
    do_err   = 1'b0;
    err_sel  = ERR_NONE;
    wait_hit = (gpio_obs[cur_idx] == (cur_op == OP_WAIT_HIGH));
    case (cur_op)
      OP_NOP, OP_END: advance = 1'b1;
      OP_DRIVE: begin
        if (idx_bad) begin
          do_err  = 1'b1;
          err_sel = ERR_ILLEGAL;
        end else begin
          advance = 1'b1;
        end
      end
      OP_WAIT_HIGH, OP_WAIT_LOW: begin
        if (idx_bad) begin
          do_err  = 1'b1;
          err_sel = ERR_ILLEGAL;
        end else if (wait_hit) begin
          advance = 1'b1;
        end else if ((cur_arg != '0) && (cnt >= arg_m1)) begin
          do_err  = 1'b1;
          err_sel = ERR_TIMEOUT;
        end
      end
      OP_DELAY: advance = (cur_arg <= ARG_W'(1)) || (cnt >= arg_m1);
      default: begin
        do_err  = 1'b1;
        err_sel = ERR_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= '0;
      cnt        <= '0;
      gpio_in_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      err_code_o <= ERR_NONE;
      fail_pc_o  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state      <= ST_RUN;
            pc         <= '0;
            cnt        <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            err_code_o <= ERR_NONE;
          end
        end
        ST_RUN: begin
          if (do_err) begin
            state      <= ST_ERR;
            cnt        <= '0;
            busy_o     <= 1'b0;
            error_o    <= 1'b1;
            err_code_o <= err_sel;
            fail_pc_o  <= pc;
          end else if (advance) begin
            cnt <= '0;
            if (cur_op == OP_DRIVE) begin
              gpio_in_o[cur_idx] <= cur_val;
            end
            if ((cur_op == OP_END) || (pc == PC_LAST)) begin
              state  <= ST_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + ARG_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_stim_seq.sv
// Directed testbench for gpio_stim_seq; honours GPIO_STIM_SYNC_EN for the
// extra observation latency.
module tb_gpio_stim_seq;
  import gpio_stim_pkg::*;

  localparam int NUM_GPIO = 32;
  localparam int DEPTH    = 16;
  localparam int ARG_W    = 24;
  localparam int ENTRY_W  = 3 + 5 + 1 + ARG_W;
`ifdef GPIO_STIM_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start_i = 1'b0;
  logic [NUM_GPIO-1:0] gpio_out_i = '0;
  logic [NUM_GPIO-1:0] gpio_in_o;
  logic                prog_we_i = 1'b0;
  logic [3:0]          prog_addr_i = '0;
  logic [ENTRY_W-1:0]  prog_data_i = '0;
  logic                busy_o, done_o, error_o;
  logic [1:0]          err_code_o;
  logic [3:0]          fail_pc_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_gpio = '0;

  always #5 clk = ~clk;

  gpio_stim_seq #(.NUM_GPIO(NUM_GPIO), .DEPTH(DEPTH), .ARG_W(ARG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .gpio_out_i  (gpio_out_i),
    .gpio_in_o   (gpio_in_o),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .err_code_o  (err_code_o),
    .fail_pc_o   (fail_pc_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input op_e op, input int idx, input logic val, input int arg);
    entry_t e;
    e.op  = op;
    e.idx = 5'(idx);
    e.val = val;
    e.arg = 24'(arg);
    return e;
  endfunction

  task automatic prog(input int a, input entry_t e);
    @(negedge clk);
    prog_we_i   = 1'b1;
    prog_addr_i = 4'(a);
    prog_data_i = e;
    @(negedge clk);
    prog_we_i = 1'b0;
  endtask

  // Returns at the negedge right after the edge that entered RUN.
  task automatic start_run();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cycles(2);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_gpio", gpio_in_o, 0);
    check("rst_code", err_code_o, 0);
    rst_n = 1'b1;
    gpio_out_i[3] = 1'b1;

    // DRIVE 4=1, END
    prog(0, mk(OP_DRIVE, 4, 1'b1, 0));
    prog(1, mk(OP_END, 0, 1'b0, 0));
    start_run();
    check("t1_busy0", busy_o, 1);
    check("t1_gpio0", gpio_in_o, 0);
    cycles(1);
    exp_gpio[4] = 1'b1;
    check("t1_gpio1", gpio_in_o, exp_gpio);
    check("t1_busy1", busy_o, 1);
    check("t1_done1", done_o, 0);
    cycles(1);
    check("t1_done2", done_o, 1);
    check("t1_busy2", busy_o, 0);

    // WAIT_HIGH 0 forever, DRIVE 7=1, END
    prog(0, mk(OP_WAIT_HIGH, 0, 1'b0, 0));
    prog(1, mk(OP_DRIVE, 7, 1'b1, 0));
    prog(2, mk(OP_END, 0, 1'b0, 0));
    start_run();
    check("t2_clr_done", done_o, 0);
    cycles(50);
    check("t2_wait_busy", busy_o, 1);
    check("t2_wait_gpio", gpio_in_o, exp_gpio);
    gpio_out_i[0] = 1'b1;
    cycles(LAT + 1);
    check("t2_pre_drive", gpio_in_o, exp_gpio);
    cycles(1);
    exp_gpio[7] = 1'b1;
    check("t2_drive", gpio_in_o, exp_gpio);
    cycles(1);
    check("t2_done", done_o, 1);

    // WAIT_LOW 3 arg=10 with bit 3 held high -> timeout
    prog(0, mk(OP_WAIT_LOW, 3, 1'b0, 10));
    prog(1, mk(OP_END, 0, 1'b0, 0));
    start_run();
    cycles(9);
    check("t3_not_yet", error_o, 0);
    check("t3_busy9", busy_o, 1);
    cycles(1);
    check("t3_error", error_o, 1);
    check("t3_code", err_code_o, 2'b01);
    check("t3_fail_pc", fail_pc_o, 0);
    check("t3_busy", busy_o, 0);
    check("t3_gpio_kept", gpio_in_o, exp_gpio);

    // DELAY 100, opcode 7 -> illegal at pc 1 after 101 cycles
    prog(0, mk(OP_DELAY, 0, 1'b0, 100));
    prog(1, mk(OP_ILL7, 0, 1'b0, 0));
    start_run();
    check("t4_clr_err", error_o, 0);
    check("t4_clr_code", err_code_o, 0);
    cycles(100);
    check("t4_e100_err", error_o, 0);
    check("t4_e100_busy", busy_o, 1);
    cycles(1);
    check("t4_error", error_o, 1);
    check("t4_code", err_code_o, 2'b10);
    check("t4_fail_pc", fail_pc_o, 1);

    // NOP, DELAY 0, DRIVE 1=1, END
    prog(0, mk(OP_NOP, 0, 1'b0, 0));
    prog(1, mk(OP_DELAY, 0, 1'b0, 0));
    prog(2, mk(OP_DRIVE, 1, 1'b1, 0));
    prog(3, mk(OP_END, 0, 1'b0, 0));
    start_run();
    cycles(2);
    check("t5_pre", gpio_in_o, exp_gpio);
    cycles(1);
    exp_gpio[1] = 1'b1;
    check("t5_drive", gpio_in_o, exp_gpio);
    cycles(1);
    check("t5_done", done_o, 1);

    // 16 DRIVE entries, no END
    for (int i = 0; i < 16; i++) prog(i, mk(OP_DRIVE, i + 8, ~i[0], 0));
    start_run();
    cycles(15);
    check("t6_busy15", busy_o, 1);
    cycles(1);
    check("t6_done16", done_o, 1);
    exp_gpio = exp_gpio | 32'h0055_5500;
    check("t6_gpio", gpio_in_o, exp_gpio);
    start_run();
    cycles(4);
    start_i     = 1'b1;
    prog_we_i   = 1'b1;
    prog_addr_i = 4'd15;
    prog_data_i = mk(OP_ILL6, 0, 1'b0, 0);
    cycles(1);
    start_i   = 1'b0;
    prog_we_i = 1'b0;
    cycles(10);
    check("t6r_busy15", busy_o, 1);
    cycles(1);
    check("t6r_done16", done_o, 1);
    check("t6r_noerr", error_o, 0);
    check("t6r_gpio", gpio_in_o, exp_gpio);

    // Reset in the middle of DELAY 1000
    prog(0, mk(OP_DRIVE, 2, 1'b1, 0));
    prog(1, mk(OP_DELAY, 0, 1'b0, 1000));
    prog(2, mk(OP_END, 0, 1'b0, 0));
    start_run();
    cycles(20);
    check("t7_busy_pre", busy_o, 1);
    rst_n = 1'b0;
    cycles(1);
    check("t7_rst_busy", busy_o, 0);
    check("t7_rst_gpio", gpio_in_o, 0);
    check("t7_rst_done", done_o, 0);
    rst_n = 1'b1;
    start_run();
    cycles(1);
    check("t7_rerun_gpio", gpio_in_o, 32'h0000_0004);
    cycles(1000);
    check("t7_e1001_busy", busy_o, 1);
    cycles(1);
    check("t7_done", done_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
